store_pack_buffer: RTL and testbench

STORE_PACK_BUFFER -- requirements
Module: store_pack_buffer

---
 rtl/store_pack_buffer.sv | 117 +++++++++++
 tb/tb_store_pack_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_pack_buffer.sv
// Store packer feeding a 2-entry FIFO: lane-replicates sb/sh/sw data, builds byte
// enables, traps misaligned stores as AdES, and presents the FIFO head to the bus.
module store_pack_buffer #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  input  logic [1:0]                  LS_op,
  output logic                        bus_valid,
  input  logic                        bus_ready,
  output logic [31:0]                 bus_addr,
  output logic [NUM_LANES*LANE_W-1:0] bus_wdata,
  output logic [NUM_LANES-1:0]        bus_byteen,
  output logic                        exc_valid,
  output logic [4:0]                  exc_code,
  output logic [31:0]                 exc_addr,
  output logic                        idle
);

  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                            r_state;
  logic                              r_wptr, r_rptr;
  logic [31:0]                       r_addr [2];
  logic [NUM_LANES*LANE_W-1:0]       r_data [2];
  logic [NUM_LANES-1:0]              r_be   [2];
  logic                              r_exc_valid;
  logic [4:0]                        r_exc_code;
  logic [31:0]                       r_exc_addr;

  logic [NUM_LANES-1:0][LANE_W-1:0]  w_lane;
  logic [NUM_LANES-1:0]              w_be;
  logic                              w_fault, w_accept, w_push, w_pop;

  // Per-lane replication: byte stores fan byte 0 everywhere, half stores alternate
  // the two low bytes, word stores pass straight through.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_lane[g] = (LS_op == 2'b10) ? req_wdata[LANE_W-1:0] :
                       (LS_op == 2'b01) ? req_wdata[LANE_W*(g%2) +: LANE_W] :
                                          req_wdata[LANE_W*g +: LANE_W];
    assign w_be[g]   = (LS_op == 2'b10) ? (req_addr[1:0] == 2'(g)) :
                       (LS_op == 2'b01) ? (req_addr[1] == (g >= 2)) :
                                          1'b1;
  end

  always_comb begin
    w_fault = 1'b0;
    case (LS_op)
      2'b00:   w_fault = (req_addr[1:0] != 2'b00);
      2'b01:   w_fault = req_addr[0];
      2'b10:   w_fault = 1'b0;
      default: w_fault = 1'b1;
    endcase
  end

  assign req_ready = !reset && (r_state != FULL);
  assign bus_valid = (r_state != EMPTY);
  assign idle      = (r_state == EMPTY);
  assign bus_addr  = r_addr[r_rptr];
  assign bus_wdata = r_data[r_rptr];
  assign bus_byteen = r_be[r_rptr];
  assign exc_valid = r_exc_valid;
  assign exc_code  = r_exc_code;
  assign exc_addr  = r_exc_addr;

  // Faulting requests still handshake but never reach the FIFO.
  assign w_accept = req_valid && req_ready;
  assign w_push   = w_accept && !w_fault;
  assign w_pop    = bus_valid && bus_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_addr[0]   <= '0;
      r_addr[1]   <= '0;
      r_data[0]   <= '0;
      r_data[1]   <= '0;
      r_be[0]     <= '0;
      r_be[1]     <= '0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= '0;
      r_exc_addr  <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wptr] <= {req_addr[31:2], 2'b00};
        r_data[r_wptr] <= w_lane;
        r_be[r_wptr]   <= w_be;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;

      case (r_state)
        EMPTY:   if (w_push) r_state <= ONE;
        ONE: begin
          if (w_push && !w_pop)      r_state <= FULL;
          else if (!w_push && w_pop) r_state <= EMPTY;
        end
        FULL:    if (w_pop) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase

      r_exc_valid <= w_accept && w_fault;
      r_exc_code  <= (w_accept && w_fault) ? EXC_ADES : 5'd0;
      if (w_accept && w_fault) r_exc_addr <= req_addr;
    end
  end

endmodule

// File: tb/tb_store_pack_buffer.sv
// Directed + random stores against a queue scoreboard of packed bus entries;
// a negedge monitor checks handshake, head contents and exception pulses.
module tb_store_pack_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  LS_op = 2'b00;
  logic        bus_valid;
  logic        bus_ready = 1'b1;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_addr;
  logic        idle;

  store_pack_buffer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .LS_op(LS_op),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t        q[$];
  int          ncmp = 0;
  int          nfail = 0;
  bit          pend = 1'b0;
  logic [31:0] last_exc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t pack(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    exp_t e;
    e.a = {a[31:2], 2'b00};
    case (op)
      2'b10: begin e.d = {4{d[7:0]}};  e.be = 4'b0001 << a[1:0]; end
      2'b01: begin e.d = {2{d[15:0]}}; e.be = a[1] ? 4'b1100 : 4'b0011; end
      default: begin e.d = d; e.be = 4'b1111; end
    endcase
    return e;
  endfunction

  function automatic bit is_fault(input logic [31:0] a, input logic [1:0] op);
    return (op == 2'b11) || (op == 2'b01 && a[0]) || (op == 2'b00 && a[1:0] != 2'b00);
  endfunction

  // Outputs are checked between edges; the scoreboard is updated with whatever
  // the coming rising edge will pop and push.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      pend = 1'b0;
      last_exc = '0;
    end else begin
      chk("bus_valid", 32'(bus_valid), 32'(q.size() != 0));
      chk("idle", 32'(idle), 32'(q.size() == 0));
      chk("req_ready", 32'(req_ready), 32'(q.size() < 2));
      chk("exc_valid", 32'(exc_valid), 32'(pend));
      chk("exc_code", 32'(exc_code), pend ? 32'd5 : 32'd0);
      chk("exc_addr", exc_addr, last_exc);
      if (q.size() != 0) begin
        chk("bus_addr", bus_addr, q[0].a);
        chk("bus_wdata", bus_wdata, q[0].d);
        chk("bus_byteen", 32'(bus_byteen), 32'(q[0].be));
        if (bus_ready) void'(q.pop_front());
      end
      pend = 1'b0;
      if (req_valid && req_ready) begin
        if (is_fault(req_addr, LS_op)) begin
          pend = 1'b1;
          last_exc = req_addr;
        end else begin
          q.push_back(pack(req_addr, req_wdata, LS_op));
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    req_valid = 1'b1; req_addr = a; req_wdata = d; LS_op = op;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    present(a, d, op);
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!idle && n < 50);
    chk("idle_timeout", 32'(idle), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_bus_byteen"}, 32'(bus_byteen), 32'd0);
    chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
    chk({tag, "_exc_code"}, 32'(exc_code), 32'd0);
    chk({tag, "_exc_addr"}, exc_addr, 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Byte, half and word packing
    store(32'h0000_1003, 32'h1234_56AB, 2'b10);
    @(posedge clk); #1;
    store(32'h0000_2002, 32'hFFFF_BEEF, 2'b01);
    store(32'h0000_2004, 32'hCAFE_F00D, 2'b00);
    store(32'h0000_2101, 32'h0000_0055, 2'b10);
    store(32'h0000_2100, 32'h0000_7788, 2'b01);
    wait_idle();

    // Misaligned word, misaligned half, reserved op
    store(32'h0000_3002, 32'h1111_1111, 2'b00);
    @(posedge clk); #1;
    store(32'h0000_3101, 32'h2222_2222, 2'b01);
    store(32'h0000_3200, 32'h3333_3333, 2'b11);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two fill the FIFO, third waits until the bus drains
    bus_ready = 1'b0;
    store(32'h0000_4000, 32'hA0A0_A0A0, 2'b00);
    store(32'h0000_4006, 32'h0000_B1B1, 2'b01);
    present(32'h0000_4009, 32'h0000_00C2, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_bus_addr", bus_addr, 32'h0000_4000);
    chk("full_bus_wdata", bus_wdata, 32'hA0A0_A0A0);
    bus_ready = 1'b1;
    wait_accept();
    wait_idle();

    // Push and pop together in ONE; the new entry becomes the head
    store(32'h0000_5000, 32'h5555_0000, 2'b00);
    store(32'h0000_5004, 32'h5555_0004, 2'b00);
    chk("pushpop_head", bus_addr, 32'h0000_5004);
    chk("pushpop_idle", 32'(idle), 32'd0);
    // Fault accepted alongside a pop: only the pop takes effect
    store(32'h0000_5102, 32'h6666_6666, 2'b00);
    chk("faultpop_idle", 32'(idle), 32'd1);
    wait_idle();

    // Reset while FULL
    bus_ready = 1'b0;
    store(32'h0000_6000, 32'h7777_7777, 2'b00);
    store(32'h0000_6004, 32'h8888_8888, 2'b00);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    bus_ready = 1'b1;
    #1;
    chk("ready_after_midreset", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    store(32'h0000_7002, 32'h0000_9A9A, 2'b01);
    wait_idle();

    // Random mix including faults
    for (int i = 0; i < 16; i++) begin
      store(32'h0000_8000 + 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)));
    end
    wait_idle();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
